// File: rtl/gate_tester_seq.sv
// gate_tester_seq: steps a 2-input gate through all input patterns,
// samples its output and scores it against an expected truth table.
module gate_tester_seq #(
  parameter int unsigned DWELL = 4,
  parameter logic [3:0]  TT    = 4'b1000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       L,
  output logic       SW0,
  output logic       SW1,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR,
  output logic [2:0] ERRCNT
);

  // A zero dwell would never reach the sample cycle; run it as 1.
  localparam int unsigned DW   = (DWELL == 0) ? 1 : DWELL;
  localparam logic [7:0]  LAST = 8'(DW - 1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    FINISH
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic [1:0] sw_q, sw_d;

  // State, counters, scores and the registered gate drive.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      err_q   <= 4'd0;
      pass_q  <= 1'b0;
      sw_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      sw_q    <= sw_d;
    end
  end

  // Next-state logic; the drive follows the next state so it
  // switches on the same edge as the state itself.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = APPLY;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
          err_d   = 4'd0;
          pass_d  = 1'b0;
        end
      end
      APPLY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        err_d[idx_q] = (L != TT[idx_q]);
        if (idx_q == 2'd3) begin
          state_d = FINISH;
          pass_d  = ~|err_d;
        end else begin
          state_d = APPLY;
          idx_d   = idx_q + 2'd1;
          cnt_d   = 8'd0;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sw_d = ((state_d == APPLY) || (state_d == SAMPLE)) ? idx_d : 2'b00;
  end

  assign SW0    = sw_q[0];
  assign SW1    = sw_q[1];
  assign BUSY   = (state_q == APPLY) || (state_q == SAMPLE);
  assign DONE   = (state_q == FINISH);
  assign PASS   = pass_q;
  assign ERR    = err_q;
  assign ERRCNT = {2'b00, err_q[0]} + {2'b00, err_q[1]}
                + {2'b00, err_q[2]} + {2'b00, err_q[3]};

endmodule

// File: tb/tb_gate_tester_seq.sv
// tb_gate_tester_seq: two sequencer instances (AND2/dwell 4, XOR2/dwell 1)
// checked cycle by cycle against arithmetic timing and truth-table rules.
module tb_gate_tester_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic go;
  logic sel;

  logic [3:0] luta, lutb;
  logic sta, la, sw0a, sw1a, busya, donea, passa;
  logic [3:0] erra;
  logic [2:0] errcnta;
  logic stb, lb, sw0b, sw1b, busyb, doneb, passb;
  logic [3:0] errb;
  logic [2:0] errcntb;

  assign sta = go && !sel;
  assign stb = go && sel;
  assign la  = luta[{sw1a, sw0a}];
  assign lb  = lutb[{sw1b, sw0b}];

  gate_tester_seq #(.DWELL(4), .TT(4'b1000)) u_a (
    .CLK(clk), .RST_N(rst_n), .START(sta), .L(la),
    .SW0(sw0a), .SW1(sw1a), .BUSY(busya), .DONE(donea),
    .PASS(passa), .ERR(erra), .ERRCNT(errcnta)
  );

  gate_tester_seq #(.DWELL(1), .TT(4'b0110)) u_b (
    .CLK(clk), .RST_N(rst_n), .START(stb), .L(lb),
    .SW0(sw0b), .SW1(sw1b), .BUSY(busyb), .DONE(doneb),
    .PASS(passb), .ERR(errb), .ERRCNT(errcntb)
  );

  logic [1:0] cur_sw;
  logic       cur_busy, cur_done, cur_pass;
  logic [3:0] cur_err;
  logic [2:0] cur_cnt;
  assign cur_sw   = sel ? {sw1b, sw0b} : {sw1a, sw0a};
  assign cur_busy = sel ? busyb : busya;
  assign cur_done = sel ? doneb : donea;
  assign cur_pass = sel ? passb : passa;
  assign cur_err  = sel ? errb : erra;
  assign cur_cnt  = sel ? errcntb : errcnta;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_sw"}, cur_sw, 0);
    chk({nm, "_busy"}, cur_busy, 0);
    chk({nm, "_done"}, cur_done, 0);
    chk({nm, "_pass"}, cur_pass, 0);
    chk({nm, "_err"}, cur_err, 0);
    chk({nm, "_cnt"}, cur_cnt, 0);
  endtask

  // Counts negedges until DONE, giving up after budget cycles.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!cur_done && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One full run: pattern k/(D+1) in cycle k after the START edge,
  // DONE in cycle 4*(D+1), then scores held in IDLE.
  task automatic run(input string nm, input logic [3:0] lut,
                     input logic [3:0] xerr, input int xcnt,
                     input logic xpass, input int pulse_at,
                     input bit fin_pulse);
    int d;
    int n;
    d = sel ? 1 : 4;
    n = 4 * (d + 1);
    if (sel) lutb = lut;
    else luta = lut;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk({nm, "_sw"}, cur_sw, k / (d + 1));
      chk({nm, "_busy"}, cur_busy, 1);
      chk({nm, "_done"}, cur_done, 0);
      if (k == 0) begin
        chk({nm, "_pass0"}, cur_pass, 0);
        chk({nm, "_err0"}, cur_err, 0);
      end
      go = (k == pulse_at);
      @(negedge clk);
    end
    go = fin_pulse;
    chk({nm, "_done"}, cur_done, 1);
    chk({nm, "_fbusy"}, cur_busy, 0);
    chk({nm, "_fsw"}, cur_sw, 0);
    chk({nm, "_err"}, cur_err, xerr);
    chk({nm, "_cnt"}, cur_cnt, xcnt);
    chk({nm, "_pass"}, cur_pass, xpass);
    @(negedge clk);
    go = 1'b0;
    chk({nm, "_idone"}, cur_done, 0);
    chk({nm, "_ibusy"}, cur_busy, 0);
    chk({nm, "_ierr"}, cur_err, xerr);
    chk({nm, "_ipass"}, cur_pass, xpass);
    @(negedge clk);
    chk({nm, "_ibusy2"}, cur_busy, 0);
    chk({nm, "_ierr2"}, cur_err, xerr);
  endtask

  typedef struct {
    string      nm;
    logic [3:0] lut;
    logic [3:0] err;
    int         cnt;
    logic       pass;
  } vec_t;

  vec_t vt[4];

  initial begin
    int n;
    logic [3:0] lut;
    logic [3:0] tt;
    logic [3:0] xerr;

    vt[0] = '{"and2",  4'b1000, 4'b0000, 0, 1'b1};
    vt[1] = '{"stuck", 4'b0000, 4'b1000, 1, 1'b0};
    vt[2] = '{"or2",   4'b1110, 4'b0110, 2, 1'b0};
    vt[3] = '{"and2b", 4'b1000, 4'b0000, 0, 1'b1};

    rst_n = 1'b0;
    go    = 1'b1;
    sel   = 1'b0;
    luta  = 4'b1000;
    lutb  = 4'b0110;

    repeat (3) @(negedge clk);
    chk_zero("rst_a");
    sel = 1'b1;
    #1;
    chk_zero("rst_b");
    sel = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_busy", cur_busy, 1);
    chk("rel_sw", cur_sw, 0);
    go = 1'b0;
    wait_done(40, n);
    chk("rel_lat", n, 20);
    chk("rel_pass", cur_pass, 1);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++)
      run(vt[i].nm, vt[i].lut, vt[i].err, vt[i].cnt, vt[i].pass, -1, 1'b0);

    run("ign", 4'b1000, 4'b0000, 0, 1'b1, 7, 1'b1);
    run("ign2", 4'b0000, 4'b1000, 1, 1'b0, 13, 1'b0);

    luta = 4'b1000;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (cur_sw != 2'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach", n, 10);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    repeat (2) begin
      @(negedge clk);
      chk("mid_nodone", cur_done, 0);
    end
    rst_n = 1'b1;
    run("restart", 4'b1000, 4'b0000, 0, 1'b1, -1, 1'b0);

    sel = 1'b1;
    run("xor", 4'b0110, 4'b0000, 0, 1'b1, -1, 1'b0);
    run("xnor", 4'b1001, 4'b1111, 4, 1'b0, 3, 1'b1);

    lutb = 4'b0110;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    wait_done(20, n);
    chk("b2b_lat1", n, 8);
    chk("b2b_pass1", cur_pass, 1);
    @(negedge clk);
    chk("b2b_idle", cur_busy, 0);
    @(negedge clk);
    chk("b2b_busy", cur_busy, 1);
    chk("b2b_sw", cur_sw, 0);
    chk("b2b_pclr", cur_pass, 0);
    go = 1'b0;
    wait_done(20, n);
    chk("b2b_lat2", n, 8);
    chk("b2b_pass2", cur_pass, 1);
    chk("b2b_err2", cur_err, 0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      sel  = i[0];
      lut  = 4'($urandom_range(0, 15));
      tt   = sel ? 4'b0110 : 4'b1000;
      xerr = lut ^ tt;
      run("rand", lut, xerr, $countones(xerr), (xerr == 4'd0),
          int'($urandom_range(0, 25)) - 5, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_tester_seq.md
# gate_tester_seq

Self-checking sequencer for a two-input combinational gate driven from SW0/SW1 and observed on L. On a START request it steps the gate inputs through all four patterns {SW1,SW0} = 00, 01, 10, 11, holds each for a programmable dwell time, and samples L. It compares each sample with a parameterised expected truth table, then reports per-pattern mismatches, a mismatch count and a pass flag. It sits between the board push-button/LED logic and the gate under test, and lets the exam gates be checked on hardware without manual switch toggling.

## Interface

Parameters:
- DWELL, default 4: APPLY cycles per pattern before the sample cycle; legal range 1..255.
- TT, default 4'b1000: expected L per pattern; bit index = {SW1,SW0} (default = AND2).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST_N  input  1  one clock; reset is asynchronous and active-low.
- START  input  1  run request; sampled only in IDLE.
- L  input  1  gate output under test; combinational from SW0/SW1, same clock domain, no synchroniser.
- SW0  output  1  gate input 0, registered.
- SW1  output  1  gate input 1, registered.
- BUSY  output  1  high in APPLY and SAMPLE.
- DONE  output  1  one-cycle pulse, high in FINISH.
- PASS  output  1  1 when last run had zero mismatches; held until next run starts or reset.
- ERR  output  4  per-pattern mismatch bits from last run; bit i = pattern i.
- ERRCNT  output  3  population count of ERR, 0..4.

## Operation

- State: 2-bit pattern index idx, 8-bit dwell counter cnt, ERR register.
- FSM states and transitions:
  - IDLE: START=1 -> APPLY. Same edge sets idx=0, cnt=0, ERR=0, PASS=0.
  - APPLY: cnt increments each cycle. At cnt==DWELL-1 -> SAMPLE.
  - SAMPLE: one cycle. The edge leaving SAMPLE sets ERR[idx] = (L != TT[idx]). If idx==3 -> FINISH; else idx+1, cnt=0 -> APPLY.
  - FINISH: one cycle, unconditional -> IDLE.
- Output decode:
  - {SW1,SW0} = idx in APPLY and SAMPLE; 00 in IDLE and FINISH.
  - Outputs are registered, so the drive changes on the same edge as the state.
- PASS is loaded on the edge entering FINISH, computed from the updated ERR (includes pattern 3).
- ERRCNT is combinational popcount of ERR.
- START outside IDLE is ignored, including START during FINISH. START held high continuously causes back-to-back runs: FINISH -> IDLE -> APPLY.
- ERR, ERRCNT and PASS keep last-run values in IDLE until the next START.
- DWELL=0 is unsupported; implementation may treat it as 1.

## Timing

- Reset, asynchronous, any state: state=IDLE, idx=0, cnt=0, SW0=SW1=0, BUSY=0, DONE=0, PASS=0, ERR=0, ERRCNT=0.
- Reset mid-run aborts the run with no DONE. The first START after deassertion runs all four patterns from idx 0.
- With START sampled at edge 0:
  - Pattern i is driven from edge i*(DWELL+1) for DWELL+1 cycles.
  - L for pattern i is sampled at edge (i+1)*(DWELL+1), i.e. after DWELL+1 cycles of stable inputs.
- FINISH is entered at edge 4*(DWELL+1). DONE and PASS are valid in the following cycle; IDLE is re-entered one edge later.
- Total run latency is START edge to DONE high = 4*(DWELL+1) cycles. For DWELL=4 this is 20.

## Test plan

- Reset: hold RST_N=0 with START=1 -> all outputs 0, SW=00; release -> run starts on first edge with START=1.
- AND2 pass: DWELL=4, TT=1000, L=SW0&SW1, START pulse -> SW sequence 00/01/10/11 each 5 cycles, DONE at +20 cycles, PASS=1, ERR=0000, ERRCNT=0.
- Stuck-at-0: L tied 0, TT=1000 -> ERR=1000, ERRCNT=1, PASS=0.
- Wrong gate: L=SW0|SW1, TT=1000 -> ERR=0110, ERRCNT=2, PASS=0. A following run with correct AND -> PASS=1, ERR=0000.
- Abort and ignore:
  - START pulse during BUSY -> no effect on idx or timing.
  - RST_N low while idx=2 -> outputs reset, no DONE. Restart -> full 4-pattern run.
- Minimum dwell: DWELL=1, TT=0110, L=SW0^SW1 -> each pattern 2 cycles, DONE at +8 cycles, PASS=1. START held high -> second run begins 2 cycles after first DONE.
